// File: rtl/axi_lite_arbiter_pkg.sv
// Shared definitions for the two-port AXI-Lite arbiter.
// Holds the default bus widths, AXI response codes, the arbiter FSM state
// encoding and the two-port round-robin pick function.
package axi_lite_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_RESP_WIDTH = 3;

    localparam logic [2:0] RESP_OKAY   = 3'd0;
    localparam logic [2:0] RESP_SLVERR = 3'd2;
    localparam logic [2:0] RESP_DECERR = 3'd3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4
    } arb_state_e;

    // One-hot pick between two requesters; on a tie the port named by ptr wins.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic ptr);
        logic [1:0] pick;
        if (req == 2'b11) begin
            pick = ptr ? 2'b10 : 2'b01;
        end else begin
            pick = req;
        end
        return pick;
    endfunction

endpackage

// File: rtl/axi_lite_arbiter_if.sv
// AXI-Lite bundle carrying the five channels (AW, W, B, AR, R).
// master modport: the side that issues addresses/data (drives valids).
// slave  modport: the side that accepts them (drives readies and responses).
interface axi_lite_arbiter_if #(
    parameter int DATA_WIDTH = axi_lite_pkg::DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = axi_lite_pkg::DEF_ADDR_WIDTH,
    parameter int RESP_WIDTH = axi_lite_pkg::DEF_RESP_WIDTH
) ();

    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [RESP_WIDTH-1:0]   bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [RESP_WIDTH-1:0]   rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axi_lite_arbiter_rr.sv
// Two-requester round-robin arbiter.
// Ports: clk/rst (sync, active-high), req[1:0] request per port,
//        advance (pulse when the current grant is taken), grant[1:0] one-hot pick.
// The pointer flips to the port that was not granted at the moment the grant
// is taken, so by the time the owner releases the bus the other port is favoured.
module rr_arbiter_2
    import axi_lite_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr_q;
    logic ptr_d;

    assign grant = rr_pick(req, ptr_q);

    // Next pointer: after serving port 0 favour port 1, and vice versa.
    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = grant[0];
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register, port 0 favoured out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/axi_lite_arbiter.sv
// Two-port AXI-Lite arbiter onto one shared downstream slave.
// Ports: axi_aclk (rising edge), axi_areset (sync, active-high),
//        s0/s1 upstream masters (slave modport), m0 downstream (master modport),
//        grant[1:0] one-hot owner of m0, 0 while idle.
// One transaction is outstanding on m0 at a time; the granted port's channels
// are muxed straight through, the other port sees zeros.
module axi_lite_arbiter
    import axi_lite_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int RESP_WIDTH = DEF_RESP_WIDTH
) (
    input  logic              axi_aclk,
    input  logic              axi_areset,
    axi_lite_arbiter_if.slave  s0,
    axi_lite_arbiter_if.slave  s1,
    axi_lite_arbiter_if.master m0,
    output logic [1:0]        grant
);

    arb_state_e state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;

    logic [1:0] wr_req_s;
    logic [1:0] req_s;
    logic [1:0] arb_grant_s;
    logic       advance_s;
    logic       sel_s;
    logic       aw_hs_s;
    logic       w_hs_s;

    logic [ADDR_WIDTH-1:0]   sel_awaddr_s;
    logic                    sel_awvalid_s;
    logic [DATA_WIDTH-1:0]   sel_wdata_s;
    logic [DATA_WIDTH/8-1:0] sel_wstrb_s;
    logic                    sel_wvalid_s;
    logic                    sel_bready_s;
    logic [ADDR_WIDTH-1:0]   sel_araddr_s;
    logic                    sel_arvalid_s;
    logic                    sel_rready_s;

    logic m0_awvalid_s, m0_wvalid_s, m0_bready_s, m0_arvalid_s, m0_rready_s;

    logic [1:0]            up_awready_s, up_wready_s, up_bvalid_s, up_arready_s, up_rvalid_s;
    logic [RESP_WIDTH-1:0] up_bresp_s [2];
    logic [RESP_WIDTH-1:0] up_rresp_s [2];
    logic [DATA_WIDTH-1:0] up_rdata_s [2];

    assign wr_req_s = {s1.awvalid & s1.wvalid, s0.awvalid & s0.wvalid};
    assign req_s    = wr_req_s | {s1.arvalid, s0.arvalid};
    assign sel_s    = grant_q[1];
    assign grant    = grant_q;

    rr_arbiter_2 u_rr (
        .clk     (axi_aclk),
        .rst     (axi_areset),
        .req     (req_s),
        .advance (advance_s),
        .grant   (arb_grant_s)
    );

    // Pick the granted port's request-side signals.
    always_comb begin
        if (sel_s) begin
            sel_awaddr_s  = s1.awaddr;
            sel_awvalid_s = s1.awvalid;
            sel_wdata_s   = s1.wdata;
            sel_wstrb_s   = s1.wstrb;
            sel_wvalid_s  = s1.wvalid;
            sel_bready_s  = s1.bready;
            sel_araddr_s  = s1.araddr;
            sel_arvalid_s = s1.arvalid;
            sel_rready_s  = s1.rready;
        end else begin
            sel_awaddr_s  = s0.awaddr;
            sel_awvalid_s = s0.awvalid;
            sel_wdata_s   = s0.wdata;
            sel_wstrb_s   = s0.wstrb;
            sel_wvalid_s  = s0.wvalid;
            sel_bready_s  = s0.bready;
            sel_araddr_s  = s0.araddr;
            sel_arvalid_s = s0.arvalid;
            sel_rready_s  = s0.rready;
        end
    end

    // Downstream valids/readies, qualified by the phase of the transaction.
    // A write channel that already handshook stays quiet until the other finishes.
    always_comb begin
        m0_awvalid_s = 1'b0;
        m0_wvalid_s  = 1'b0;
        m0_bready_s  = 1'b0;
        m0_arvalid_s = 1'b0;
        m0_rready_s  = 1'b0;
        case (state_q)
            WR_ADDR: begin
                m0_awvalid_s = sel_awvalid_s & ~aw_done_q;
                m0_wvalid_s  = sel_wvalid_s & ~w_done_q;
            end
            WR_RESP: m0_bready_s  = sel_bready_s;
            RD_ADDR: m0_arvalid_s = sel_arvalid_s;
            RD_DATA: m0_rready_s  = sel_rready_s;
            default: m0_awvalid_s = 1'b0;
        endcase
    end

    assign m0.awaddr  = sel_awaddr_s;
    assign m0.awvalid = m0_awvalid_s;
    assign m0.wdata   = sel_wdata_s;
    assign m0.wstrb   = sel_wstrb_s;
    assign m0.wvalid  = m0_wvalid_s;
    assign m0.bready  = m0_bready_s;
    assign m0.araddr  = sel_araddr_s;
    assign m0.arvalid = m0_arvalid_s;
    assign m0.rready  = m0_rready_s;

    assign aw_hs_s = m0_awvalid_s & m0.awready;
    assign w_hs_s  = m0_wvalid_s & m0.wready;

    // Upstream readies and responses: only the granted port sees anything non-zero.
    always_comb begin
        up_awready_s  = 2'b00;
        up_wready_s   = 2'b00;
        up_bvalid_s   = 2'b00;
        up_arready_s  = 2'b00;
        up_rvalid_s   = 2'b00;
        up_bresp_s[0] = '0;
        up_bresp_s[1] = '0;
        up_rresp_s[0] = '0;
        up_rresp_s[1] = '0;
        up_rdata_s[0] = '0;
        up_rdata_s[1] = '0;
        case (state_q)
            WR_ADDR: begin
                up_awready_s[sel_s] = m0.awready & ~aw_done_q;
                up_wready_s[sel_s]  = m0.wready & ~w_done_q;
            end
            WR_RESP: begin
                up_bvalid_s[sel_s] = m0.bvalid;
                up_bresp_s[sel_s]  = m0.bresp;
            end
            RD_ADDR: up_arready_s[sel_s] = m0.arready;
            RD_DATA: begin
                up_rvalid_s[sel_s] = m0.rvalid;
                up_rdata_s[sel_s]  = m0.rdata;
                up_rresp_s[sel_s]  = m0.rresp;
            end
            default: up_awready_s = 2'b00;
        endcase
    end

    assign s0.awready = up_awready_s[0];
    assign s0.wready  = up_wready_s[0];
    assign s0.bvalid  = up_bvalid_s[0];
    assign s0.bresp   = up_bresp_s[0];
    assign s0.arready = up_arready_s[0];
    assign s0.rvalid  = up_rvalid_s[0];
    assign s0.rdata   = up_rdata_s[0];
    assign s0.rresp   = up_rresp_s[0];
    assign s1.awready = up_awready_s[1];
    assign s1.wready  = up_wready_s[1];
    assign s1.bvalid  = up_bvalid_s[1];
    assign s1.bresp   = up_bresp_s[1];
    assign s1.arready = up_arready_s[1];
    assign s1.rvalid  = up_rvalid_s[1];
    assign s1.rdata   = up_rdata_s[1];
    assign s1.rresp   = up_rresp_s[1];

    // Next-state logic for the transaction FSM, grant and write-channel done flags.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        advance_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_grant_s != 2'b00) begin
                    grant_d   = arb_grant_s;
                    advance_s = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    // Within the winning port a write beats a simultaneous read.
                    if ((arb_grant_s & wr_req_s) != 2'b00) begin
                        state_d = WR_ADDR;
                    end else begin
                        state_d = RD_ADDR;
                    end
                end else begin
                    grant_d = 2'b00;
                end
            end
            WR_ADDR: begin
                aw_done_d = aw_done_q | aw_hs_s;
                w_done_d  = w_done_q | w_hs_s;
                if (aw_done_d && w_done_d) begin
                    state_d   = WR_RESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end else begin
                    state_d = WR_ADDR;
                end
            end
            WR_RESP: begin
                if (m0.bvalid && m0_bready_s) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                end else begin
                    state_d = WR_RESP;
                end
            end
            RD_ADDR: begin
                if (m0_arvalid_s && m0.arready) begin
                    state_d = RD_DATA;
                end else begin
                    state_d = RD_ADDR;
                end
            end
            RD_DATA: begin
                if (m0.rvalid && m0_rready_s) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                end else begin
                    state_d = RD_DATA;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    // State, grant and done-flag registers; reset abandons any open transaction.
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            state_q   <= IDLE;
            grant_q   <= 2'b00;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed self-checking bench for axi_lite_arbiter.
module tb_axi_lite_arbiter;
    import axi_lite_pkg::*;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int RW = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] grant;
    logic       cnt_clr;
    int         checks = 0;
    int         errors = 0;
    int         aw_cnt = 0;
    int         w_cnt  = 0;

    always #5 clk = ~clk;

    axi_lite_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW)) if_s0 ();
    axi_lite_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW)) if_s1 ();
    axi_lite_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW)) if_m0 ();

    axi_lite_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW)) dut (
        .axi_aclk   (clk),
        .axi_areset (rst),
        .s0         (if_s0),
        .s1         (if_s1),
        .m0         (if_m0),
        .grant      (grant)
    );

    // Count downstream AW and W handshakes.
    always @(posedge clk) begin
        if (cnt_clr) begin
            aw_cnt <= 0;
            w_cnt  <= 0;
        end else begin
            if (if_m0.awvalid && if_m0.awready) aw_cnt <= aw_cnt + 1;
            if (if_m0.wvalid && if_m0.wready) w_cnt <= w_cnt + 1;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        if_s0.awaddr = 8'h00; if_s0.awvalid = 1'b0; if_s0.wdata = 32'h0; if_s0.wstrb = 4'h0;
        if_s0.wvalid = 1'b0; if_s0.bready = 1'b0; if_s0.araddr = 8'h00; if_s0.arvalid = 1'b0;
        if_s0.rready = 1'b0;
        if_s1.awaddr = 8'h00; if_s1.awvalid = 1'b0; if_s1.wdata = 32'h0; if_s1.wstrb = 4'h0;
        if_s1.wvalid = 1'b0; if_s1.bready = 1'b0; if_s1.araddr = 8'h00; if_s1.arvalid = 1'b0;
        if_s1.rready = 1'b0;
        if_m0.awready = 1'b0; if_m0.wready = 1'b0; if_m0.bresp = 3'd0; if_m0.bvalid = 1'b0;
        if_m0.arready = 1'b0; if_m0.rdata = 32'h0; if_m0.rresp = 3'd0; if_m0.rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_all();
        if_s0.awvalid = 1'b1; if_s0.wvalid = 1'b1; if_s1.arvalid = 1'b1;
        if_m0.awready = 1'b1; if_m0.wready = 1'b1; if_m0.arready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            @(negedge clk);
            checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant got %b exp 00", grant); end
            checks++; if (if_m0.awvalid !== 1'b0 || if_m0.arvalid !== 1'b0 || if_m0.wvalid !== 1'b0) begin
                errors++; $display("FAIL rst_m0_valids got aw%b w%b ar%b exp 0", if_m0.awvalid, if_m0.wvalid, if_m0.arvalid); end
            checks++; if (if_s0.awready !== 1'b0 || if_s0.wready !== 1'b0 || if_s1.arready !== 1'b0) begin
                errors++; $display("FAIL rst_readies got aw%b w%b ar%b exp 0", if_s0.awready, if_s0.wready, if_s1.arready); end
        end
        next_cycle();
        idle_all();
        rst = 1'b0;
    endtask

    task automatic test_single_write();
        next_cycle();
        if_s0.awaddr = 8'h00; if_s0.awvalid = 1'b1; if_s0.wdata = 32'd56; if_s0.wstrb = 4'hF;
        if_s0.wvalid = 1'b1; if_s0.bready = 1'b1;
        if_m0.awready = 1'b1; if_m0.wready = 1'b1; if_m0.bvalid = 1'b0; if_m0.bresp = RESP_OKAY;
        @(negedge clk);
        checks++; if (grant !== 2'b00 || if_m0.awvalid !== 1'b0) begin
            errors++; $display("FAIL wr_latency got grant %b awvalid %b exp 00 0", grant, if_m0.awvalid); end
        next_cycle();
        @(negedge clk);
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL wr_grant got %b exp 01", grant); end
        checks++; if (if_m0.awvalid !== 1'b1 || if_m0.awaddr !== 8'h00) begin
            errors++; $display("FAIL wr_m0_aw got v%b a%h exp v1 a00", if_m0.awvalid, if_m0.awaddr); end
        checks++; if (if_m0.wvalid !== 1'b1 || if_m0.wdata !== 32'd56 || if_m0.wstrb !== 4'hF) begin
            errors++; $display("FAIL wr_m0_w got v%b d%0d s%h exp v1 d56 sF", if_m0.wvalid, if_m0.wdata, if_m0.wstrb); end
        checks++; if (if_s0.awready !== 1'b1 || if_s1.awready !== 1'b0 || if_s1.wready !== 1'b0) begin
            errors++; $display("FAIL wr_readies got s0aw%b s1aw%b s1w%b exp 1 0 0", if_s0.awready, if_s1.awready, if_s1.wready); end
        next_cycle();
        if_s0.awvalid = 1'b0; if_s0.wvalid = 1'b0;
        if_m0.bvalid = 1'b1; if_m0.bresp = RESP_OKAY;
        @(negedge clk);
        checks++; if (if_s0.bvalid !== 1'b1 || if_s0.bresp !== RESP_OKAY || if_s1.bvalid !== 1'b0) begin
            errors++; $display("FAIL wr_bresp got s0b%b r%0d s1b%b exp 1 0 0", if_s0.bvalid, if_s0.bresp, if_s1.bvalid); end
        next_cycle();
        if_m0.bvalid = 1'b0; if_s0.bready = 1'b0;
        @(negedge clk);
        checks++; if (grant !== 2'b00 || if_s0.bvalid !== 1'b0) begin
            errors++; $display("FAIL wr_done got grant %b bvalid %b exp 00 0", grant, if_s0.bvalid); end
    endtask

    task automatic test_simultaneous_write();
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        if_s0.awaddr = 8'h04; if_s0.wdata = 32'h11; if_s0.wstrb = 4'hF; if_s0.bready = 1'b1;
        if_s0.awvalid = 1'b1; if_s0.wvalid = 1'b1;
        if_s1.awaddr = 8'h08; if_s1.wdata = 32'h22; if_s1.wstrb = 4'hF; if_s1.bready = 1'b1;
        if_s1.awvalid = 1'b1; if_s1.wvalid = 1'b1;
        if_m0.awready = 1'b1; if_m0.wready = 1'b1; if_m0.bvalid = 1'b1; if_m0.bresp = RESP_OKAY;
        @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL sim_idle got %b exp 00", grant); end
        next_cycle();
        @(negedge clk);
        checks++; if (grant !== 2'b01 || if_m0.awaddr !== 8'h04) begin
            errors++; $display("FAIL sim_first got grant %b addr %h exp 01 04", grant, if_m0.awaddr); end
        next_cycle();
        if_s0.awvalid = 1'b0; if_s0.wvalid = 1'b0;
        @(negedge clk);
        checks++; if (grant !== 2'b01 || if_s0.bvalid !== 1'b1 || if_s1.bvalid !== 1'b0) begin
            errors++; $display("FAIL sim_first_b got grant %b s0b %b s1b %b exp 01 1 0", grant, if_s0.bvalid, if_s1.bvalid); end
        next_cycle();
        @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL sim_gap got %b exp 00", grant); end
        next_cycle();
        @(negedge clk);
        checks++; if (grant !== 2'b10 || if_m0.awaddr !== 8'h08 || if_s1.awready !== 1'b1 || if_s0.awready !== 1'b0) begin
            errors++; $display("FAIL sim_second got grant %b addr %h s1aw %b s0aw %b exp 10 08 1 0",
                               grant, if_m0.awaddr, if_s1.awready, if_s0.awready); end
        next_cycle();
        if_s1.awvalid = 1'b0; if_s1.wvalid = 1'b0;
        @(negedge clk);
        checks++; if (grant !== 2'b10 || if_s1.bvalid !== 1'b1 || if_s0.bvalid !== 1'b0) begin
            errors++; $display("FAIL sim_second_b got grant %b s1b %b s0b %b exp 10 1 0", grant, if_s1.bvalid, if_s0.bvalid); end
        next_cycle();
        idle_all();
        @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL sim_end got %b exp 00", grant); end
    endtask

    task automatic test_read();
        next_cycle();
        if_s1.araddr = 8'h18; if_s1.arvalid = 1'b1; if_s1.rready = 1'b1; if_s0.rready = 1'b1;
        if_m0.arready = 1'b1;
        @(negedge clk);
        checks++; if (if_m0.arvalid !== 1'b0) begin errors++; $display("FAIL rd_latency got %b exp 0", if_m0.arvalid); end
        next_cycle();
        @(negedge clk);
        checks++; if (grant !== 2'b10 || if_m0.arvalid !== 1'b1 || if_m0.araddr !== 8'h18) begin
            errors++; $display("FAIL rd_addr got grant %b v %b a %h exp 10 1 18", grant, if_m0.arvalid, if_m0.araddr); end
        checks++; if (if_s1.arready !== 1'b1 || if_s0.arready !== 1'b0) begin
            errors++; $display("FAIL rd_arready got s1 %b s0 %b exp 1 0", if_s1.arready, if_s0.arready); end
        next_cycle();
        if_s1.arvalid = 1'b0;
        if_m0.rvalid = 1'b1; if_m0.rdata = 32'd76; if_m0.rresp = RESP_OKAY;
        @(negedge clk);
        checks++; if (if_s1.rvalid !== 1'b1 || if_s1.rdata !== 32'd76 || if_s1.rresp !== RESP_OKAY) begin
            errors++; $display("FAIL rd_data got v %b d %0d r %0d exp 1 76 0", if_s1.rvalid, if_s1.rdata, if_s1.rresp); end
        checks++; if (if_s0.rvalid !== 1'b0 || if_s0.rdata !== 32'd0) begin
            errors++; $display("FAIL rd_other got v %b d %0d exp 0 0", if_s0.rvalid, if_s0.rdata); end
        next_cycle();
        idle_all();
        @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rd_done got %b exp 00", grant); end
    endtask

    task automatic test_split_handshake();
        next_cycle();
        cnt_clr = 1'b1;
        if_s0.awaddr = 8'h2C; if_s0.awvalid = 1'b1; if_s0.wdata = 32'hA5; if_s0.wstrb = 4'h3;
        if_s0.wvalid = 1'b1; if_s0.bready = 1'b1;
        if_m0.awready = 1'b1; if_m0.wready = 1'b0; if_m0.bvalid = 1'b1; if_m0.bresp = RESP_DECERR;
        next_cycle();
        cnt_clr = 1'b0;
        @(negedge clk);
        checks++; if (if_m0.awvalid !== 1'b1 || if_m0.wvalid !== 1'b1 || if_s0.wready !== 1'b0) begin
            errors++; $display("FAIL split_start got aw %b w %b wr %b exp 1 1 0", if_m0.awvalid, if_m0.wvalid, if_s0.wready); end
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            if_s0.awvalid = 1'b0;
            @(negedge clk);
            checks++; if (if_m0.awvalid !== 1'b0 || if_m0.wvalid !== 1'b1 || if_s0.bvalid !== 1'b0) begin
                errors++; $display("FAIL split_wait%0d got aw %b w %b b %b exp 0 1 0", i, if_m0.awvalid, if_m0.wvalid, if_s0.bvalid); end
        end
        next_cycle();
        if_m0.wready = 1'b1;
        @(negedge clk);
        checks++; if (if_m0.wvalid !== 1'b1 || if_s0.wready !== 1'b1 || if_s0.bvalid !== 1'b0) begin
            errors++; $display("FAIL split_w got w %b wr %b b %b exp 1 1 0", if_m0.wvalid, if_s0.wready, if_s0.bvalid); end
        next_cycle();
        if_s0.wvalid = 1'b0; if_m0.wready = 1'b0;
        @(negedge clk);
        checks++; if (if_s0.bvalid !== 1'b1 || if_s0.bresp !== RESP_DECERR) begin
            errors++; $display("FAIL split_resp got b %b r %0d exp 1 3", if_s0.bvalid, if_s0.bresp); end
        checks++; if (aw_cnt !== 1 || w_cnt !== 1) begin
            errors++; $display("FAIL split_counts got aw %0d w %0d exp 1 1", aw_cnt, w_cnt); end
        next_cycle();
        idle_all();
        @(negedge clk);
        checks++; if (grant !== 2'b00 || aw_cnt !== 1 || w_cnt !== 1) begin
            errors++; $display("FAIL split_end got grant %b aw %0d w %0d exp 00 1 1", grant, aw_cnt, w_cnt); end
    endtask

    task automatic test_reset_in_wr_resp();
        next_cycle();
        if_s0.awaddr = 8'h10; if_s0.awvalid = 1'b1; if_s0.wdata = 32'h5; if_s0.wstrb = 4'hF;
        if_s0.wvalid = 1'b1; if_s0.bready = 1'b1;
        if_m0.awready = 1'b1; if_m0.wready = 1'b1; if_m0.bvalid = 1'b0;
        next_cycle();
        next_cycle();
        if_s0.awvalid = 1'b0; if_s0.wvalid = 1'b0;
        @(negedge clk);
        checks++; if (grant !== 2'b01 || if_s0.bvalid !== 1'b0 || if_m0.bready !== 1'b1) begin
            errors++; $display("FAIL rstwr_resp_state got grant %b b %b br %b exp 01 0 1", grant, if_s0.bvalid, if_m0.bready); end
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        if_m0.bvalid = 1'b1; if_m0.bresp = RESP_SLVERR;
        @(negedge clk);
        checks++; if (grant !== 2'b00 || if_s0.bvalid !== 1'b0 || if_s1.bvalid !== 1'b0) begin
            errors++; $display("FAIL rstwr_abandon got grant %b s0b %b s1b %b exp 00 0 0", grant, if_s0.bvalid, if_s1.bvalid); end
        checks++; if (if_m0.bready !== 1'b0 || if_m0.awvalid !== 1'b0 || if_s0.awready !== 1'b0 || if_s0.wready !== 1'b0) begin
            errors++; $display("FAIL rstwr_handshake got br %b aw %b awr %b wr %b exp 0 0 0 0",
                               if_m0.bready, if_m0.awvalid, if_s0.awready, if_s0.wready); end
        next_cycle();
        idle_all();
        @(negedge clk);
        checks++; if (if_s0.bvalid !== 1'b0 || grant !== 2'b00) begin
            errors++; $display("FAIL rstwr_after got b %b grant %b exp 0 00", if_s0.bvalid, grant); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_g;
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        if_s0.araddr = 8'h40; if_s0.arvalid = 1'b1; if_s0.rready = 1'b1;
        if_s1.araddr = 8'h80; if_s1.arvalid = 1'b1; if_s1.rready = 1'b1;
        if_m0.arready = 1'b1; if_m0.rvalid = 1'b1; if_m0.rresp = RESP_SLVERR;
        @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL b2b_idle got %b exp 00", grant); end
        for (int k = 0; k < 8; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            next_cycle();
            if_m0.rdata = 32'(100 + k);
            @(negedge clk);
            checks++; if (grant !== exp_g || if_m0.arvalid !== 1'b1 || if_m0.araddr !== ((exp_g == 2'b01) ? 8'h40 : 8'h80)) begin
                errors++; $display("FAIL b2b_addr%0d got grant %b v %b a %h exp %b 1", k, grant, if_m0.arvalid, if_m0.araddr, exp_g); end
            next_cycle();
            @(negedge clk);
            checks++; if (grant !== exp_g
                          || ((exp_g == 2'b01) ? if_s0.rvalid : if_s1.rvalid) !== 1'b1
                          || ((exp_g == 2'b01) ? if_s1.rvalid : if_s0.rvalid) !== 1'b0
                          || ((exp_g == 2'b01) ? if_s0.rdata : if_s1.rdata) !== 32'(100 + k)
                          || ((exp_g == 2'b01) ? if_s0.rresp : if_s1.rresp) !== RESP_SLVERR) begin
                errors++; $display("FAIL b2b_data%0d got grant %b s0v %b s1v %b s0d %0d s1d %0d exp %b data %0d",
                                   k, grant, if_s0.rvalid, if_s1.rvalid, if_s0.rdata, if_s1.rdata, exp_g, 100 + k); end
            next_cycle();
            if (k == 7) idle_all();
            @(negedge clk);
            checks++; if (grant !== 2'b00) begin errors++; $display("FAIL b2b_gap%0d got %b exp 00", k, grant); end
        end
    endtask

    initial begin
        rst     = 1'b1;
        cnt_clr = 1'b1;
        idle_all();
        test_reset();
        cnt_clr = 1'b0;
        test_single_write();
        test_simultaneous_write();
        test_read();
        test_split_handshake();
        test_reset_in_wr_resp();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
